// File: rtl/mux_4bit_3i_1o_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_4bit_3i_1o_pkg
// Description : Shared definitions for the three-source bus selector.
//               Select encodings are exported so the control unit drives
//               the selector with named values instead of magic numbers.
// Contents    : sel_t      - 2-bit select encoding (A, B, C, illegal)
//               c_SEL_W    - width of the select field
//               calc_parity- even-parity helper (XOR reduction)
// Revision    : 1.0 - initial release
// ============================================================================
package mux_4bit_3i_1o_pkg;

    localparam int unsigned c_SEL_W = 2;

    // Select encodings; SEL_BAD is reserved and flagged by the top level.
    typedef enum logic [c_SEL_W-1:0] {
        SEL_A   = 2'd0,
        SEL_B   = 2'd1,
        SEL_C   = 2'd2,
        SEL_BAD = 2'd3
    } sel_t;

    // Even-parity bit over a 32-bit field; narrower data is zero-extended,
    // which leaves the parity unchanged.
    function automatic logic calc_parity(input logic [31:0] i_data);
        return ^i_data;
    endfunction

endpackage : mux_4bit_3i_1o_pkg
`default_nettype wire

// File: rtl/mux_4bit_3i_1o_mux3_core.sv
`default_nettype none
// ============================================================================
// Module      : mux_4bit_3i_1o_mux3_core
// Description : Purely combinational WIDTH-bit 3:1 selector. The reserved
//               select code drives a fixed BAD_VAL pattern onto the output.
// Parameters  : WIDTH   - data width
//               BAD_VAL - value driven for the reserved select code
//                         (truncated / zero-extended to WIDTH)
// Ports       : i_sel   in  2      select (SEL_A / SEL_B / SEL_C / SEL_BAD)
//               i_a     in  WIDTH  source 0
//               i_b     in  WIDTH  source 1
//               i_c     in  WIDTH  source 2
//               o_r     out WIDTH  selected data
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4bit_3i_1o_mux3_core
    import mux_4bit_3i_1o_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned BAD_VAL = 0
) (
    input  logic [c_SEL_W-1:0] i_sel,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [WIDTH-1:0]   i_c,
    output logic [WIDTH-1:0]   o_r
);

    // Size the fill value once so the output assignment is width-exact.
    localparam logic [WIDTH-1:0] c_BAD_VAL = WIDTH'(BAD_VAL);

    // Default assignment first keeps the block latch-free; X/Z selects
    // fall through to the default arm.
    always_comb begin
        o_r = c_BAD_VAL;
        case (i_sel)
            SEL_A:   o_r = i_a;
            SEL_B:   o_r = i_b;
            SEL_C:   o_r = i_c;
            default: o_r = c_BAD_VAL;
        endcase
    end

endmodule : mux_4bit_3i_1o_mux3_core
`default_nettype wire

// File: rtl/mux_4bit_3i_1o.sv
`default_nettype none
// ============================================================================
// Module      : mux_4bit_3i_1o
// Description : Three-source bus selector with a registered copy of the
//               output and a sticky illegal-select debug flag.
// Parameters  : WIDTH   - data width of a, b, c, r, r_q (default 4)
//               BAD_VAL - value on r when s selects the reserved code
// Ports       : clk      in   1      rising-edge clock
//               rst      in   1      asynchronous active-high reset
//               s        in   2      select: 0->a, 1->b, 2->c, 3->illegal
//               a, b, c  in   WIDTH  data sources
//               err_clr  in   1      synchronous clear of sel_err
//               r        out  WIDTH  combinational selector output
//               r_q      out  WIDTH  r registered on clk
//               sel_err  out  1      sticky illegal-select flag
//               r_par    out  1      even parity of r      (MUX_PARITY_EN)
//               r_par_q  out  1      registered parity     (MUX_PARITY_EN)
// Build option: define MUX_PARITY_EN to add the r_par / r_par_q outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4bit_3i_1o
    import mux_4bit_3i_1o_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned BAD_VAL = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [c_SEL_W-1:0] s,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   r,
    output logic [WIDTH-1:0]   r_q,
    output logic               sel_err
`ifdef MUX_PARITY_EN
    ,
    output logic               r_par,
    output logic               r_par_q
`endif
);

    logic [WIDTH-1:0] w_r;
    logic             w_sel_bad;
    logic [WIDTH-1:0] r_out_q;
    logic             r_sel_err;

    mux_4bit_3i_1o_mux3_core #(
        .WIDTH   (WIDTH),
        .BAD_VAL (BAD_VAL)
    ) u_core (
        .i_sel (s),
        .i_a   (a),
        .i_b   (b),
        .i_c   (c),
        .o_r   (w_r)
    );

    assign w_sel_bad = (s == SEL_BAD);

    // Registered copy of the selector output, one cycle behind r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q <= '0;
        end else begin
            r_out_q <= w_r;
        end
    end

    // Sticky flag: a reserved select seen at an edge wins over a clear
    // requested in the same cycle, so no illegal event is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (w_sel_bad) begin
            r_sel_err <= 1'b1;
        end else if (err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

    assign r       = w_r;
    assign r_q     = r_out_q;
    assign sel_err = r_sel_err;

`ifdef MUX_PARITY_EN
    logic w_par;
    logic r_par_reg;

    assign w_par = calc_parity(32'(w_r));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_reg <= 1'b0;
        end else begin
            r_par_reg <= w_par;
        end
    end

    assign r_par   = w_par;
    assign r_par_q = r_par_reg;
`endif

endmodule : mux_4bit_3i_1o
`default_nettype wire

// File: tb/tb_mux_4bit_3i_1o.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4bit_3i_1o
// Description : Directed self-checking bench for mux_4bit_3i_1o. Expected
//               values are written by hand next to each stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4bit_3i_1o;

    localparam int c_WIDTH = 4;

    logic               clk;
    logic               rst;
    logic [1:0]         s;
    logic [c_WIDTH-1:0] a;
    logic [c_WIDTH-1:0] b;
    logic [c_WIDTH-1:0] c;
    logic               err_clr;
    logic [c_WIDTH-1:0] r;
    logic [c_WIDTH-1:0] r_q;
    logic               sel_err;
`ifdef MUX_PARITY_EN
    logic               r_par;
    logic               r_par_q;
`endif

    int n_checks;
    int n_fails;

    mux_4bit_3i_1o #(
        .WIDTH   (c_WIDTH),
        .BAD_VAL (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s       (s),
        .a       (a),
        .b       (b),
        .c       (c),
        .err_clr (err_clr),
        .r       (r),
        .r_q     (r_q),
        .sel_err (sel_err)
`ifdef MUX_PARITY_EN
        ,
        .r_par   (r_par),
        .r_par_q (r_par_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    initial begin
        logic [c_WIDTH-1:0] exp_r;
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        s        = 2'd0;
        a        = '0;
        b        = '0;
        c        = '0;
        err_clr  = 1'b0;

        // Reset state
        #2;
        check("reset_r_q", 8'(r_q), 8'h0);
        check("reset_sel_err", 8'(sel_err), 8'h0);
        rst = 1'b0;

        // Sweep: s=0..2, each of a,b,c in {0,1}
        for (int si = 0; si < 3; si++) begin
            for (int v = 0; v < 8; v++) begin
                s = 2'(si);
                a = c_WIDTH'(v & 1);
                b = c_WIDTH'((v >> 1) & 1);
                c = c_WIDTH'((v >> 2) & 1);
                #10;
                exp_r = (si == 0) ? c_WIDTH'(v & 1) :
                        (si == 1) ? c_WIDTH'((v >> 1) & 1) :
                                    c_WIDTH'((v >> 2) & 1);
                check($sformatf("sweep_s%0d_v%0d", si, v), 8'(r), 8'(exp_r));
            end
        end

        // Distinct patterns, including the reserved select
        a = 4'h5; b = 4'hA; c = 4'hF;
        s = 2'd0; #1; check("pat_s0", 8'(r), 8'h5);
        s = 2'd1; #1; check("pat_s1", 8'(r), 8'hA);
        s = 2'd2; #1; check("pat_s2", 8'(r), 8'hF);
        s = 2'd3; #1; check("pat_s3_bad", 8'(r), 8'h0);

        // Reset with s=1, b=9; release and load on the first edge
        @(negedge clk);
        s = 2'd1; b = 4'h9; rst = 1'b1;
        #1;
        check("rst_r_q", 8'(r_q), 8'h0);
        check("rst_sel_err", 8'(sel_err), 8'h0);
        check("rst_r_live", 8'(r), 8'h9);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_r_q", 8'(r_q), 8'h9);
        check("post_rst_r", 8'(r), 8'h9);

        // Sticky illegal-select flag
        @(negedge clk); s = 2'd3;
        @(posedge clk); #1;
        check("err_set", 8'(sel_err), 8'h1);
        check("r_q_bad", 8'(r_q), 8'h0);
        @(negedge clk); s = 2'd0; err_clr = 1'b0;
        @(posedge clk); #1;
        check("err_hold", 8'(sel_err), 8'h1);
        check("r_q_a", 8'(r_q), 8'h5);
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1;
        check("err_clear", 8'(sel_err), 8'h0);
        @(negedge clk); s = 2'd3; err_clr = 1'b1;
        @(posedge clk); #1;
        check("err_set_wins", 8'(sel_err), 8'h1);

        // Async reset between edges clears r_q before the next edge
        @(negedge clk); s = 2'd2; c = 4'hF; err_clr = 1'b0;
        @(posedge clk); #1;
        check("pre_async_r_q", 8'(r_q), 8'hF);
        check("pre_async_err", 8'(sel_err), 8'h1);
        #1; rst = 1'b1;
        #1;
        check("async_r_q", 8'(r_q), 8'h0);
        check("async_sel_err", 8'(sel_err), 8'h0);
        check("async_r_live", 8'(r), 8'hF);
        @(negedge clk); rst = 1'b0;

`ifdef MUX_PARITY_EN
        s = 2'd2; c = 4'h7; #1;
        check("par_7", 8'(r_par), 8'h1);
        @(posedge clk); #1;
        check("par_q_7", 8'(r_par_q), 8'h1);
        @(negedge clk); c = 4'h3; #1;
        check("par_3", 8'(r_par), 8'h0);
        check("par_q_hold", 8'(r_par_q), 8'h1);
        @(posedge clk); #1;
        check("par_q_3", 8'(r_par_q), 8'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_mux_4bit_3i_1o
`default_nettype wire
